// File: rtl/icmp_echo_pkg.sv
// Shared types, constants and checksum helper for the ICMPv4 echo responder.
package icmp_echo_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_DROP,
    S_CHECK,
    S_SEND
  } state_t;

  // Word indices within the captured packet (IPv4 header with IHL=5).
  localparam int unsigned W_SRC  = 3;
  localparam int unsigned W_DST  = 4;
  localparam int unsigned W_ICMP = 5;

  localparam logic [3:0] IP_VER        = 4'd4;
  localparam logic [3:0] IHL_MIN       = 4'd5;
  localparam logic [7:0] PROTO_ICMP    = 8'd1;
  localparam logic [7:0] ICMP_ECHO_REQ = 8'd8;
  localparam logic [7:0] ICMP_ECHO_REP = 8'd0;

  // Ones-complement 16-bit add with end-around carry.
  function automatic logic [15:0] csum_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/icmp_pkt_buffer.sv
// Simple dual-port packet buffer: synchronous write, combinational read.
module icmp_pkt_buffer #(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [31:0]              wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [31:0]              rd_data
);

  logic [31:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/icmp_echo_responder.sv
// Store-and-forward ICMPv4 echo responder on 32-bit Avalon-ST (tun, no L2).
// Optional statistics counters enabled by defining ICMP_ECHO_STATS_EN.
module icmp_echo_responder
  import icmp_echo_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] stream_in_data,
  input  logic [1:0]  stream_in_empty,
  input  logic        stream_in_valid,
  input  logic        stream_in_startofpacket,
  input  logic        stream_in_endofpacket,
  output logic        stream_in_ready,
  output logic [31:0] stream_out_data,
  output logic [1:0]  stream_out_empty,
  output logic        stream_out_valid,
  output logic        stream_out_startofpacket,
  output logic        stream_out_endofpacket,
  input  logic        stream_out_ready,
  output logic        drop_pulse
`ifdef ICMP_ECHO_STATS_EN
  ,
  output logic [15:0] rx_pkt_count,
  output logic [15:0] tx_pkt_count,
  output logic [15:0] drop_count
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, last_ptr_q, rd_ptr_q;
  logic [1:0]         empty_q;
  logic               loaded_last_q;
  logic               word0_ok_q, word2_ok_q, word5_ok_q;

  logic               in_xfer_c, out_xfer_c, can_load_c, pkt_ok_c, is_last_c;
  logic               wr_en_c, cap_c, drop_c, load_c, clear_valid_c, start_send_c;
  logic [PTR_W-1:0]   wr_addr_c, rd_addr_c;
  logic [31:0]        rd_data, out_word_c;
  logic [15:0]        csum_c;

  assign in_xfer_c  = stream_in_valid && stream_in_ready;
  assign out_xfer_c = stream_out_valid && stream_out_ready;
  assign can_load_c = !stream_out_valid || stream_out_ready;
  assign is_last_c  = (rd_ptr_q == last_ptr_q);
  assign pkt_ok_c   = word0_ok_q && word2_ok_q && word5_ok_q &&
                      (last_ptr_q >= PTR_W'(W_ICMP));

  icmp_pkt_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en_c),
    .wr_addr (wr_addr_c),
    .wr_data (stream_in_data),
    .rd_addr (rd_addr_c),
    .rd_data (rd_data)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and control strobes.
  always_comb begin
    state_d       = state_q;
    wr_en_c       = 1'b0;
    wr_addr_c     = wr_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    cap_c         = 1'b0;
    drop_c        = 1'b0;
    load_c        = 1'b0;
    clear_valid_c = 1'b0;
    start_send_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_xfer_c && stream_in_startofpacket) begin
          if (stream_in_endofpacket) begin
            drop_c = 1'b1;
          end else begin
            wr_en_c   = 1'b1;
            wr_addr_c = '0;
            wr_ptr_d  = PTR_W'(1);
            state_d   = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (in_xfer_c) begin
          if (stream_in_startofpacket) begin
            // Restart capture; the abandoned packet counts as a drop.
            drop_c    = 1'b1;
            wr_addr_c = '0;
            if (stream_in_endofpacket) begin
              state_d = S_IDLE;
            end else begin
              wr_en_c  = 1'b1;
              wr_ptr_d = PTR_W'(1);
            end
          end else begin
            wr_en_c = 1'b1;
            if (stream_in_endofpacket) begin
              cap_c   = 1'b1;
              state_d = S_CHECK;
            end else if (wr_ptr_q == PTR_W'(DEPTH - 1)) begin
              state_d = S_DROP;
            end else begin
              wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
          end
        end
      end
      S_DROP: begin
        if (in_xfer_c && stream_in_endofpacket) begin
          drop_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (pkt_ok_c) begin
          start_send_c = 1'b1;
          state_d      = S_SEND;
        end else begin
          drop_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (can_load_c && !loaded_last_q) begin
          load_c = 1'b1;
        end else if (out_xfer_c) begin
          clear_valid_c = 1'b1;
          if (stream_out_endofpacket) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read remap swaps source and destination address words.
  always_comb begin
    rd_addr_c = rd_ptr_q;
    if (rd_ptr_q == PTR_W'(W_SRC))      rd_addr_c = PTR_W'(W_DST);
    else if (rd_ptr_q == PTR_W'(W_DST)) rd_addr_c = PTR_W'(W_SRC);
  end

  // Echo Request -> Reply rewrite with incremental checksum update.
  always_comb begin
    csum_c     = csum_add16({rd_data[23:16], rd_data[31:24]},
                            {8'(ICMP_ECHO_REQ - ICMP_ECHO_REP), 8'h00});
    out_word_c = rd_data;
    if (rd_ptr_q == PTR_W'(W_ICMP))
      out_word_c = {csum_c[7:0], csum_c[15:8], rd_data[15:8], ICMP_ECHO_REP};
  end

  // Capture pointers, header checks and the registered output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q                 <= '0;
      last_ptr_q               <= '0;
      rd_ptr_q                 <= '0;
      empty_q                  <= '0;
      loaded_last_q            <= 1'b0;
      word0_ok_q               <= 1'b0;
      word2_ok_q               <= 1'b0;
      word5_ok_q               <= 1'b0;
      stream_in_ready          <= 1'b0;
      stream_out_data          <= '0;
      stream_out_empty         <= '0;
      stream_out_valid         <= 1'b0;
      stream_out_startofpacket <= 1'b0;
      stream_out_endofpacket   <= 1'b0;
      drop_pulse               <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      drop_pulse      <= drop_c;
      stream_in_ready <= (state_d == S_IDLE) || (state_d == S_RECV) || (state_d == S_DROP);
      if (wr_en_c && wr_addr_c == PTR_W'(0))
        word0_ok_q <= (stream_in_data[7:4] == IP_VER) && (stream_in_data[3:0] == IHL_MIN);
      if (wr_en_c && wr_addr_c == PTR_W'(2))
        word2_ok_q <= (stream_in_data[15:8] == PROTO_ICMP);
      if (wr_en_c && wr_addr_c == PTR_W'(W_ICMP))
        word5_ok_q <= (stream_in_data[7:0] == ICMP_ECHO_REQ) && (stream_in_data[15:8] == 8'h00);
      if (cap_c) begin
        last_ptr_q <= wr_ptr_q;
        empty_q    <= stream_in_empty;
      end
      if (start_send_c) begin
        rd_ptr_q      <= '0;
        loaded_last_q <= 1'b0;
      end
      if (load_c) begin
        stream_out_valid         <= 1'b1;
        stream_out_data          <= out_word_c;
        stream_out_startofpacket <= (rd_ptr_q == '0);
        stream_out_endofpacket   <= is_last_c;
        stream_out_empty         <= is_last_c ? empty_q : 2'd0;
        rd_ptr_q                 <= rd_ptr_q + PTR_W'(1);
        if (is_last_c) loaded_last_q <= 1'b1;
      end else if (clear_valid_c) begin
        stream_out_valid         <= 1'b0;
        stream_out_startofpacket <= 1'b0;
        stream_out_endofpacket   <= 1'b0;
        stream_out_empty         <= '0;
      end
    end
  end

`ifdef ICMP_ECHO_STATS_EN
  // Wrapping packet statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_pkt_count <= '0;
      tx_pkt_count <= '0;
      drop_count   <= '0;
    end else begin
      if (cap_c)                               rx_pkt_count <= rx_pkt_count + 16'd1;
      if (out_xfer_c && stream_out_endofpacket) tx_pkt_count <= tx_pkt_count + 16'd1;
      if (drop_c)                              drop_count   <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icmp_echo_responder.sv
// Directed scoreboard bench for icmp_echo_responder.
module tb_icmp_echo_responder;

  localparam int unsigned DEPTH = 64;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  empty;
    logic        sop;
    logic        eop;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] stream_in_data = '0;
  logic [1:0]  stream_in_empty = '0;
  logic        stream_in_valid = 1'b0;
  logic        stream_in_startofpacket = 1'b0;
  logic        stream_in_endofpacket = 1'b0;
  logic        stream_in_ready;
  logic [31:0] stream_out_data;
  logic [1:0]  stream_out_empty;
  logic        stream_out_valid;
  logic        stream_out_startofpacket;
  logic        stream_out_endofpacket;
  logic        stream_out_ready = 1'b1;
  logic        drop_pulse;
`ifdef ICMP_ECHO_STATS_EN
  logic [15:0] rx_pkt_count, tx_pkt_count, drop_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_beats  = 0;
  int n_drops  = 0;
  bit bp_mode  = 1'b0;

  beat_t       sb[$];
  logic [31:0] pkt[$];

  icmp_echo_responder #(.DEPTH(DEPTH)) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .stream_in_data           (stream_in_data),
    .stream_in_empty          (stream_in_empty),
    .stream_in_valid          (stream_in_valid),
    .stream_in_startofpacket  (stream_in_startofpacket),
    .stream_in_endofpacket    (stream_in_endofpacket),
    .stream_in_ready          (stream_in_ready),
    .stream_out_data          (stream_out_data),
    .stream_out_empty         (stream_out_empty),
    .stream_out_valid         (stream_out_valid),
    .stream_out_startofpacket (stream_out_startofpacket),
    .stream_out_endofpacket   (stream_out_endofpacket),
    .stream_out_ready         (stream_out_ready),
    .drop_pulse               (drop_pulse)
`ifdef ICMP_ECHO_STATS_EN
    ,
    .rx_pkt_count             (rx_pkt_count),
    .tx_pkt_count             (tx_pkt_count),
    .drop_count               (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Sink ready: always 1, or the repeating 1,0,0,1 pattern under backpressure.
  initial begin
    int k = 0;
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        stream_out_ready = (k % 4 == 0) || (k % 4 == 3);
        k++;
      end else begin
        stream_out_ready = 1'b1;
      end
    end
  end

  // Output monitor: scoreboard pop, stall stability, drop counting.
  initial begin
    bit    held = 1'b0;
    beat_t held_beat, cur, exp;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held = 1'b0;
      end else begin
        cur = '{stream_out_data, stream_out_empty, stream_out_startofpacket, stream_out_endofpacket};
        if (drop_pulse) n_drops++;
        if (held) chk("stall_hold", {27'd0, stream_out_valid, cur}, {27'd0, 1'b1, held_beat});
        if (stream_out_valid && stream_out_ready) begin
          held = 1'b0;
          n_beats++;
          if (sb.size() == 0) begin
            chk("unexpected_beat", {28'd0, cur}, 64'd0);
          end else begin
            exp = sb.pop_front();
            chk("beat", {28'd0, cur}, {28'd0, exp});
          end
        end else if (stream_out_valid) begin
          held = 1'b1;
          held_beat = cur;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  // Build an echo request of nwords words into pkt.
  task automatic build(input int nwords, input logic [15:0] c, input logic [7:0] proto);
    pkt.delete();
    for (int i = 0; i < nwords; i++) begin
      case (i)
        0: pkt.push_back(32'h0000_0045);
        2: pkt.push_back({16'h0000, proto, 8'h40});
        3: pkt.push_back(32'h0100_000A);
        4: pkt.push_back(32'h0200_000A);
        5: pkt.push_back({c[7:0], c[15:8], 16'h0008});
        default: pkt.push_back($urandom());
      endcase
    end
  endtask

  // Reference reply: swap addresses, type 0, checksum + 0x0800 end-around.
  task automatic expect_reply(input logic [1:0] e);
    beat_t b;
    logic [31:0] w;
    logic [15:0] c, n;
    int s;
    for (int i = 0; i < pkt.size(); i++) begin
      w = pkt[i];
      if (i == 3) w = pkt[4];
      if (i == 4) w = pkt[3];
      if (i == 5) begin
        c = {w[23:16], w[31:24]};
        s = int'(c) + 32'h0800;
        if (s > 32'hFFFF) s = s - 32'hFFFF;
        n = s[15:0];
        w = {n[7:0], n[15:8], w[15:8], 8'h00};
      end
      b.data  = w;
      b.sop   = (i == 0);
      b.eop   = (i == pkt.size() - 1);
      b.empty = b.eop ? e : 2'd0;
      sb.push_back(b);
    end
  endtask

  task automatic drive(input logic [1:0] e);
    int budget;
    for (int i = 0; i < pkt.size(); i++) begin
      stream_in_valid         = 1'b1;
      stream_in_data          = pkt[i];
      stream_in_startofpacket = (i == 0);
      stream_in_endofpacket   = (i == pkt.size() - 1);
      stream_in_empty         = (i == pkt.size() - 1) ? e : 2'd0;
      budget = 0;
      @(negedge clk);
      while (!stream_in_ready && budget < 500) begin
        budget++;
        @(negedge clk);
      end
      if (!stream_in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
    end
    stream_in_valid         = 1'b0;
    stream_in_startofpacket = 1'b0;
    stream_in_endofpacket   = 1'b0;
    stream_in_empty         = '0;
  endtask

  task automatic drain(input string tag);
    int budget = 0;
    while (sb.size() != 0 && budget < 3000) begin
      @(posedge clk);
      budget++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int d0, b0, budget;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {28'd0, stream_out_data, stream_out_empty, stream_out_valid,
        stream_out_startofpacket, stream_out_endofpacket, stream_in_ready, drop_pulse},
        64'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ready_after_reset", 64'(stream_in_ready), 64'd1);

    // Echo request, with first-output latency
    build(21, 16'h1234, 8'd1);
    expect_reply(2'd0);
    chk("model_csum_1234", {32'd0, sb[5].data}, {32'd0, 32'h341A_0000});
    drive(2'd0);
    chk("lat_cycle0", 64'(stream_out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_cycle1", 64'(stream_out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_cycle2", 64'(stream_out_valid), 64'd1);
    drain("echo_drain");

    // Checksum end-around carry
    build(21, 16'hF900, 8'd1);
    expect_reply(2'd0);
    chk("model_csum_f900", {32'd0, sb[5].data}, {32'd0, 32'h0101_0000});
    drive(2'd0);
    drain("wrap_drain");

    // Odd length with backpressure
    bp_mode = 1'b1;
    build(22, 16'h5555, 8'd1);
    expect_reply(2'd3);
    drive(2'd3);
    drain("bp_drain");
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Invalid protocol, then a valid request
    d0 = n_drops;
    b0 = n_beats;
    build(21, 16'h1234, 8'd6);
    drive(2'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("invalid_drop", 64'(n_drops - d0), 64'd1);
    chk("invalid_no_out", 64'(n_beats - b0), 64'd0);
    build(21, 16'hABCD, 8'd1);
    expect_reply(2'd0);
    drive(2'd0);
    drain("after_invalid_drain");

    // Oversize packet, then a valid request
    d0 = n_drops;
    b0 = n_beats;
    build(DEPTH + 4, 16'h1111, 8'd1);
    drive(2'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("oversize_drop", 64'(n_drops - d0), 64'd1);
    chk("oversize_no_out", 64'(n_beats - b0), 64'd0);
    build(21, 16'h0F0F, 8'd1);
    expect_reply(2'd0);
    drive(2'd0);
    drain("after_oversize_drain");

    // Reset while transmitting
    build(21, 16'h2222, 8'd1);
    expect_reply(2'd0);
    b0 = n_beats;
    drive(2'd0);
    budget = 0;
    while (n_beats < b0 + 5 && budget < 200) begin
      @(negedge clk); #2;
      budget++;
    end
    chk("mid_send_reached", 64'(n_beats >= b0 + 5), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("reset_mid_outputs", {28'd0, stream_out_data, stream_out_empty, stream_out_valid,
        stream_out_startofpacket, stream_out_endofpacket, stream_in_ready, drop_pulse},
        64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    build(21, 16'h3333, 8'd1);
    expect_reply(2'd0);
    drive(2'd0);
    drain("after_reset_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
